// File: rtl/sn76489_control.sv
// SN76489 register/write-port controller.
// This block decodes CPU latch/data bytes into the tone, attenuation and noise
// registers. It also produces the shared generator enable strobe and the READY
// handshake back to the CPU bus.
module sn76489_control #(
  parameter int PRESCALE    = 16,
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       ready,
  output logic       enable,
  output logic [9:0] tone0_n,
  output logic [9:0] tone1_n,
  output logic [9:0] tone2_n,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3,
  output logic [2:0] noise_ctrl,
  output logic       noise_reset
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_PENULT = PW'(PRESCALE - 2);
  localparam logic [BW-1:0] BUSY_LOAD  = BW'(BUSY_CYCLES);
  localparam logic [BW-1:0] BUSY_IDLE  = BW'(0);

  logic [PW-1:0] pre_cnt_r;
  logic          enable_r;
  logic [BW-1:0] busy_cnt_r;
  logic [BW-1:0] busy_next_s;
  logic          ready_r;
  logic [2:0]    latch_r;
  logic [9:0]    tone_r [3];
  logic [3:0]    att_r [4];
  logic [2:0]    noise_ctrl_r;
  logic          noise_reset_r;

  logic          accept_s;
  logic          is_latch_s;
  logic [2:0]    target_s;
  logic [1:0]    chan_s;
  logic          tone_lo_we_s;
  logic          tone_hi_we_s;
  logic          att_we_s;
  logic          noise_we_s;

  // Free-running prescaler. The enable output is registered, so it is set one
  // count early; it is then high in the cycle where the count is PRESCALE-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r <= '0;
      enable_r  <= 1'b0;
    end else begin
      if (pre_cnt_r == PRE_LAST) begin
        pre_cnt_r <= '0;
      end else begin
        pre_cnt_r <= pre_cnt_r + PW'(1);
      end
      enable_r <= (pre_cnt_r == PRE_PENULT);
    end
  end

  // Decode an accepted byte into the write enable for the one register it targets.
  always_comb begin
    accept_s     = wr & ready_r;
    is_latch_s   = data[7];
    tone_lo_we_s = 1'b0;
    tone_hi_we_s = 1'b0;
    att_we_s     = 1'b0;
    noise_we_s   = 1'b0;
    if (is_latch_s) begin
      target_s = data[6:4];
    end else begin
      target_s = latch_r;
    end
    chan_s = target_s[2:1];
    if (accept_s) begin
      if (target_s[0]) begin
        att_we_s = 1'b1;
      end else if (chan_s == 2'd3) begin
        noise_we_s = 1'b1;
      end else if (is_latch_s) begin
        tone_lo_we_s = 1'b1;
      end else begin
        tone_hi_we_s = 1'b1;
      end
    end else begin
      att_we_s = 1'b0;
    end
  end

  // Busy countdown: load on accept, then count down to idle. Writes made while busy do not reload it.
  always_comb begin
    if (accept_s) begin
      busy_next_s = BUSY_LOAD;
    end else if (busy_cnt_r != BUSY_IDLE) begin
      busy_next_s = busy_cnt_r - BW'(1);
    end else begin
      busy_next_s = busy_cnt_r;
    end
  end

  // Busy counter and registered READY flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_r <= BUSY_IDLE;
      ready_r    <= 1'b1;
    end else begin
      busy_cnt_r <= busy_next_s;
      ready_r    <= (busy_next_s == BUSY_IDLE);
    end
  end

  // Latch register and the sound registers it addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_r       <= 3'b000;
      noise_ctrl_r  <= 3'd0;
      noise_reset_r <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        tone_r[i] <= 10'd0;
      end
      for (int i = 0; i < 4; i++) begin
        att_r[i] <= 4'hF;
      end
    end else begin
      noise_reset_r <= noise_we_s;
      if (accept_s && is_latch_s) begin
        latch_r <= data[6:4];
      end
      if (noise_we_s) begin
        noise_ctrl_r <= data[2:0];
      end
      if (att_we_s) begin
        att_r[chan_s] <= data[3:0];
      end
      if (tone_lo_we_s || tone_hi_we_s) begin
        case (chan_s)
          2'd0: begin
            if (tone_lo_we_s) tone_r[0][3:0] <= data[3:0];
            else              tone_r[0][9:4] <= data[5:0];
          end
          2'd1: begin
            if (tone_lo_we_s) tone_r[1][3:0] <= data[3:0];
            else              tone_r[1][9:4] <= data[5:0];
          end
          2'd2: begin
            if (tone_lo_we_s) tone_r[2][3:0] <= data[3:0];
            else              tone_r[2][9:4] <= data[5:0];
          end
          default: begin
            tone_r[0] <= tone_r[0];
          end
        endcase
      end
    end
  end

  assign ready       = ready_r;
  assign enable      = enable_r;
  assign tone0_n     = tone_r[0];
  assign tone1_n     = tone_r[1];
  assign tone2_n     = tone_r[2];
  assign att0        = att_r[0];
  assign att1        = att_r[1];
  assign att2        = att_r[2];
  assign att3        = att_r[3];
  assign noise_ctrl  = noise_ctrl_r;
  assign noise_reset = noise_reset_r;

endmodule
